muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide execution unit. It sits between operand read and register writeback in the core. It takes `rs1`/`rs2` operand data and a destination index, computes over multiple cycles, then issues a single write to the register file through `rd_write_enable`/`rd`/`rd_data`. The core stalls on `busy`.

---
 rtl/muldiv_pkg.sv | 29 ++
 rtl/muldiv_unit.sv | 177 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

   typedef enum logic [2:0] {
      OP_MUL    = 3'd0,
      OP_MULH   = 3'd1,
      OP_MULHSU = 3'd2,
      OP_MULHU  = 3'd3,
      OP_DIV    = 3'd4,
      OP_DIVU   = 3'd5,
      OP_REM    = 3'd6,
      OP_REMU   = 3'd7
   } muldiv_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } muldiv_state_e;

   localparam int unsigned MulDivIterations = 32;

   // funct3 bit 2 selects the divide family; bit 1 within it selects remainder
   function automatic logic op_is_div(input muldiv_op_e op);
      return op[2];
   endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: magnitude shift-add / restoring divide
// over 32 RUN cycles, sign fix-up in FIX, single register-file write in DONE.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int DataBitWidth    = 32,
   parameter int AddressBitWidth = 5
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [2:0]                 funct3,
   input  logic [DataBitWidth-1:0]    rs1_data,
   input  logic [DataBitWidth-1:0]    rs2_data,
   input  logic [AddressBitWidth-1:0] rd_in,
   output logic                       busy,
   output logic                       done,
   output logic                       rd_write_enable,
   output logic [AddressBitWidth-1:0] rd,
   output logic [DataBitWidth-1:0]    rd_data
);

   localparam int W = DataBitWidth;

   muldiv_state_e              state_q, state_d;
   muldiv_op_e                 op_q, op_d;
   logic [AddressBitWidth-1:0] rd_q, rd_d;
   logic [W-1:0]               a_q, a_d;
   logic [W-1:0]               b_q, b_d;
   logic [2*W-1:0]             work_q, work_d;
   logic [5:0]                 cnt_q, cnt_d;
   logic                       neg_res_q, neg_res_d;
   logic                       neg_rem_q, neg_rem_d;
   logic [W-1:0]               result_q, result_d;

   muldiv_op_e     op_in_s;
   logic           s1_signed_s, s2_signed_s;
   logic           rs1_neg_s, rs2_neg_s;
   logic [W-1:0]   a_mag_s, b_mag_s;
   logic           div_zero_s, div_ovf_s;
   logic [W:0]     mul_sum_s, div_trial_s;
   logic [2*W-1:0] mul_step_s, div_step_s;
   logic [2*W-1:0] prod_fix_s;
   logic [W-1:0]   quot_fix_s, rem_fix_s;

   // Operand decode, magnitudes and one iteration of each datapath
   always_comb begin
      op_in_s     = muldiv_op_e'(funct3);
      s1_signed_s = (op_in_s == OP_MULH) || (op_in_s == OP_MULHSU) ||
                    (op_in_s == OP_DIV)  || (op_in_s == OP_REM);
      s2_signed_s = (op_in_s == OP_MULH) || (op_in_s == OP_DIV) || (op_in_s == OP_REM);
      rs1_neg_s   = s1_signed_s & rs1_data[W-1];
      rs2_neg_s   = s2_signed_s & rs2_data[W-1];
      a_mag_s     = rs1_neg_s ? -rs1_data : rs1_data;
      b_mag_s     = rs2_neg_s ? -rs2_data : rs2_data;
      div_zero_s  = op_is_div(op_in_s) && (rs2_data == '0);
      div_ovf_s   = ((op_in_s == OP_DIV) || (op_in_s == OP_REM)) &&
                    (rs1_data == {1'b1, {(W-1){1'b0}}}) && (rs2_data == '1);

      mul_sum_s   = {1'b0, work_q[2*W-1:W]} + {1'b0, a_q};
      if (work_q[0]) begin
         mul_step_s = {mul_sum_s, work_q[W-1:1]};
      end else begin
         mul_step_s = {1'b0, work_q[2*W-1:1]};
      end

      // 33-bit trial subtract: the shifted partial remainder can exceed W bits
      div_trial_s = {work_q[2*W-1:W], work_q[W-1]} - {1'b0, b_q};
      if (!div_trial_s[W]) begin
         div_step_s = {div_trial_s[W-1:0], work_q[W-2:0], 1'b1};
      end else begin
         div_step_s = {work_q[2*W-2:0], 1'b0};
      end

      prod_fix_s = neg_res_q ? -work_q : work_q;
      quot_fix_s = neg_res_q ? -work_q[W-1:0] : work_q[W-1:0];
      rem_fix_s  = neg_rem_q ? -work_q[2*W-1:W] : work_q[2*W-1:W];
   end

   // Next-state and datapath register updates
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      rd_d      = rd_q;
      a_d       = a_q;
      b_d       = b_q;
      work_d    = work_q;
      cnt_d     = cnt_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      result_d  = result_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               op_d      = op_in_s;
               rd_d      = rd_in;
               a_d       = a_mag_s;
               b_d       = b_mag_s;
               neg_res_d = rs1_neg_s ^ rs2_neg_s;
               neg_rem_d = rs1_neg_s;
               cnt_d     = 6'd0;
               if (div_zero_s) begin
                  result_d = op_in_s[1] ? rs1_data : '1;
                  state_d  = DONE;
               end else if (div_ovf_s) begin
                  result_d = op_in_s[1] ? '0 : {1'b1, {(W-1){1'b0}}};
                  state_d  = DONE;
               end else begin
                  work_d  = op_is_div(op_in_s) ? {{W{1'b0}}, a_mag_s} : {{W{1'b0}}, b_mag_s};
                  state_d = RUN;
               end
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            work_d = op_is_div(op_q) ? div_step_s : mul_step_s;
            cnt_d  = cnt_q + 6'd1;
            if (cnt_q == 6'(MulDivIterations - 1)) begin
               state_d = FIX;
            end else begin
               state_d = RUN;
            end
         end
         FIX: begin
            case (op_q)
               OP_MUL:                      result_d = prod_fix_s[W-1:0];
               OP_MULH, OP_MULHSU, OP_MULHU: result_d = prod_fix_s[2*W-1:W];
               OP_DIV, OP_DIVU:             result_d = quot_fix_s;
               OP_REM, OP_REMU:             result_d = rem_fix_s;
               default:                     result_d = '0;
            endcase
            state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         op_q      <= OP_MUL;
         rd_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         work_q    <= '0;
         cnt_q     <= 6'd0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         rd_q      <= rd_d;
         a_q       <= a_d;
         b_q       <= b_d;
         work_q    <= work_d;
         cnt_q     <= cnt_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         result_q  <= result_d;
      end
   end

   assign busy            = (state_q != IDLE);
   assign done            = (state_q == DONE);
   assign rd_write_enable = done && (rd_q != '0);
   assign rd              = rd_q;
   assign rd_data         = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit with hand-computed results.
module tb_muldiv_unit;

   logic        clk;
   logic        rst;
   logic        start;
   logic [2:0]  funct3;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic [4:0]  rd_in;
   logic        busy;
   logic        done;
   logic        rd_write_enable;
   logic [4:0]  rd;
   logic [31:0] rd_data;

   int          n_checks;
   int          n_fail;
   int          wr_count;
   logic [31:0] last_wr_data;

   muldiv_unit #(.DataBitWidth(32), .AddressBitWidth(5)) dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .funct3          (funct3),
      .rs1_data        (rs1_data),
      .rs2_data        (rs2_data),
      .rd_in           (rd_in),
      .busy            (busy),
      .done            (done),
      .rd_write_enable (rd_write_enable),
      .rd              (rd),
      .rd_data         (rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register-file write monitor
   always @(negedge clk) begin
      if (rd_write_enable) begin
         wr_count     = wr_count + 1;
         last_wr_data = rd_data;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (obs !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Issue one op, optionally re-pulse start in cycle glitch_cyc, check result and latency
   task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rdi, input logic [31:0] exp_data,
                         input int exp_lat, input int glitch_cyc);
      int cyc;
      int base;
      bit seen;
      base = wr_count;
      @(negedge clk);
      funct3   = f3;
      rs1_data = a;
      rs2_data = b;
      rd_in    = rdi;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc   = 1;
      seen  = 1'b0;
      while (cyc <= 100 && !seen) begin
         if (done) begin
            seen = 1'b1;
         end else begin
            if (cyc == glitch_cyc) begin
               start    = 1'b1;
               funct3   = 3'd0;
               rs1_data = 32'd99;
               rs2_data = 32'd99;
            end
            @(posedge clk); #1;
            start = 1'b0;
            cyc   = cyc + 1;
         end
      end
      check_eq({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
      check_eq({tag, "_data"}, rd_data, exp_data);
      check_eq({tag, "_rd"}, {27'd0, rd}, {27'd0, rdi});
      check_eq({tag, "_we"}, {31'd0, rd_write_enable}, {31'd0, (rdi != 5'd0)});
      @(posedge clk); #1;
      check_eq({tag, "_idle_after"}, {31'd0, busy}, 32'd0);
      check_eq({tag, "_writes"}, 32'(wr_count - base), (rdi != 5'd0) ? 32'd1 : 32'd0);
      if (rdi != 5'd0) begin
         check_eq({tag, "_wr_data"}, last_wr_data, exp_data);
      end
   endtask

   initial begin
      int base;
      n_checks = 0;
      n_fail   = 0;
      wr_count = 0;
      last_wr_data = 32'd0;
      rst      = 1'b1;
      start    = 1'b0;
      funct3   = 3'd0;
      rs1_data = 32'd0;
      rs2_data = 32'd0;
      rd_in    = 5'd0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("reset_busy", {31'd0, busy}, 32'd0);
      check_eq("reset_done", {31'd0, done}, 32'd0);
      check_eq("reset_we", {31'd0, rd_write_enable}, 32'd0);
      check_eq("reset_rd", {27'd0, rd}, 32'd0);
      check_eq("reset_rd_data", rd_data, 32'd0);
      rst = 1'b0;

      run_op("mul",    3'd0, 32'd7,        32'hFFFFFFFD, 5'd1, 32'hFFFFFFEB, 34, 0);
      run_op("mulhu",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'hFFFFFFFE, 34, 0);
      run_op("mulh",   3'd1, 32'h80000000, 32'h80000000, 5'd3, 32'h40000000, 34, 0);
      run_op("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 32'hFFFFFFFF, 34, 0);
      run_op("div",    3'd4, 32'hFFFFFFF9, 32'd2,        5'd5, 32'hFFFFFFFD, 34, 0);
      run_op("rem",    3'd6, 32'hFFFFFFF9, 32'd2,        5'd6, 32'hFFFFFFFF, 34, 0);
      run_op("divu",   3'd5, 32'd100,      32'd7,        5'd7, 32'd14,       34, 0);
      run_op("remu",   3'd7, 32'd100,      32'd7,        5'd8, 32'd2,        34, 0);
      run_op("divu_z", 3'd5, 32'd5,        32'd0,        5'd9, 32'hFFFFFFFF, 1,  0);
      run_op("rem_z",  3'd6, 32'd5,        32'd0,        5'd10, 32'd5,       1,  0);
      run_op("div_ov", 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000, 1, 0);
      run_op("rem_ov", 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'd0,       1,  0);
      run_op("ignore_start", 3'd0, 32'd5, 32'd6, 5'd13, 32'd30, 34, 10);
      run_op("rd_zero", 3'd0, 32'd5, 32'd6, 5'd0, 32'd30, 34, 0);

      // Abort a DIV with reset in cycle 15
      base = wr_count;
      @(negedge clk);
      funct3   = 3'd4;
      rs1_data = 32'd1000;
      rs2_data = 32'd3;
      rd_in    = 5'd14;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (14) @(posedge clk);
      #1;
      check_eq("abort_busy_before", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_eq("abort_busy_after", {31'd0, busy}, 32'd0);
      repeat (40) @(posedge clk);
      #1;
      check_eq("abort_no_write", 32'(wr_count - base), 32'd0);
      run_op("mul_after_rst", 3'd0, 32'd3, 32'd4, 5'd15, 32'd12, 34, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
